// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port memory arbiter (m0 = CPU, m1 = loader/DMA) in front of
// a single memory with fixed 1-cycle read latency.
//   clk, rst_n            : clock, asynchronous active-low reset
//   mN_req/we/addr/wdata  : requester command (held stable until granted)
//   mN_gnt                : combinational grant while port N owns the memory
//   mN_rvalid/mN_rdata    : read return, one cycle after a read beat
//   mem_en/we/addr/wdata  : memory command, driven by the current owner
//   mem_rdata             : memory read data
//   owner                 : state encoding 00 IDLE, 01 OWN0, 10 OWN1
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking and
// preemption of either owner; otherwise m0 wins ties and only OWN1 is preemptible.
module mem_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_OWN0 = 2'b01,
    S_OWN1 = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_burst_done;
  logic          w_beat0;
  logic          w_beat1;
  logic          w_tie_m1;
  logic          w_pre_own0;
  logic          w_pre_own1;
  logic          r_rv0;
  logic          r_rv1;

  // Beat counter advanced by one beat, saturating at MAX_BURST
  assign w_cnt_inc    = (r_cnt >= CW'(MAX_BURST)) ? r_cnt : r_cnt + CW'(1);
  // Count includes the current beat, so the owner gets exactly MAX_BURST beats
  // before a pending request on the other port takes over.
  assign w_burst_done = (w_cnt_inc == CW'(MAX_BURST));

  assign w_beat0 = (r_state == S_OWN0) && m0_req;
  assign w_beat1 = (r_state == S_OWN1) && m1_req;

`ifdef MEM_ARB_RR_EN
  logic r_last;

  assign w_tie_m1   = ~r_last;
  assign w_pre_own0 = m1_req;

  // Last owner: reset to m1 so m0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_state_nxt == S_OWN0) begin
      r_last <= 1'b0;
    end else if (w_state_nxt == S_OWN1) begin
      r_last <= 1'b1;
    end
  end
`else
  assign w_tie_m1   = 1'b0;
  assign w_pre_own0 = 1'b0;
`endif

  assign w_pre_own1 = m0_req;

  // State, beat counter and read-return tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rv0   <= w_beat0 & ~m0_we;
      r_rv1   <= w_beat1 & ~m1_we;
    end
  end

  // Next state, grants and memory command mux
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (m0_req && m1_req) begin
          w_state_nxt = w_tie_m1 ? S_OWN1 : S_OWN0;
        end else if (m0_req) begin
          w_state_nxt = S_OWN0;
        end else if (m1_req) begin
          w_state_nxt = S_OWN1;
        end
      end
      S_OWN0: begin
        m0_gnt    = m0_req;
        mem_en    = m0_req;
        mem_we    = m0_we;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        if (!m0_req) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_burst_done && w_pre_own0) begin
          w_state_nxt = S_OWN1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_OWN1: begin
        m1_gnt    = m1_req;
        mem_en    = m1_req;
        mem_we    = m1_we;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        if (!m1_req) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_burst_done && w_pre_own1) begin
          w_state_nxt = S_OWN0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign m0_rvalid = r_rv0;
  assign m1_rvalid = r_rv1;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;
  assign owner     = 2'(r_state);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus constrained-random traffic for
// mem_arbiter, checked every cycle against a tenure-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int MB = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr, mem_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, mem_wdata, mem_rdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_en, mem_we;
  logic [1:0]    owner;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the memory (0 none, 1 m0, 2 m1), beats granted
  // in the current tenure, last owner port, and expected read returns.
  int            md_own;
  int            md_beats;
  int            md_last;
  bit            md_rv0, md_rv1;
  logic [DW-1:0] md_rdata;
  bit            pg0, pg1;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return (a * 32'h9E3779B9) ^ 32'h12345678;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md_own = 0; md_beats = 0; md_last = 1;
    md_rv0 = 0; md_rv1 = 0; md_rdata = '0;
    pg0 = 0; pg1 = 0;
  endtask

  task automatic model_step();
    bit b0, b1, my_req, oth_req;
    int me, oth, win;
    b0 = (md_own == 1) && m0_req;
    b1 = (md_own == 2) && m1_req;
    md_rv0 = b0 && !m0_we;
    md_rv1 = b1 && !m1_we;
    if (b0) md_rdata = memf(m0_addr);
    if (b1) md_rdata = memf(m1_addr);
    if (md_own == 0) begin
      win = -1;
      if (m0_req && m1_req) win = (RR && md_last == 0) ? 1 : 0;
      else if (m0_req) win = 0;
      else if (m1_req) win = 1;
      if (win >= 0) begin
        md_own = win + 1; md_last = win; md_beats = 0;
      end
    end else begin
      me = md_own - 1;
      oth = 1 - me;
      my_req  = (me == 0) ? m0_req : m1_req;
      oth_req = (oth == 0) ? m0_req : m1_req;
      if (!my_req) begin
        md_own = 0; md_beats = 0;
      end else begin
        md_beats = (md_beats + 1 > MB) ? MB : md_beats + 1;
        if (md_beats == MB && oth_req && (RR || me == 1)) begin
          md_own = oth + 1; md_last = oth; md_beats = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit e_g0, e_g1;
    e_g0 = (md_own == 1) && m0_req;
    e_g1 = (md_own == 2) && m1_req;
    chk("owner", 64'(owner), 64'(md_own));
    chk("m0_gnt", m0_gnt, e_g0);
    chk("m1_gnt", m1_gnt, e_g1);
    chk("mem_en", mem_en, e_g0 || e_g1);
    chk("m0_rvalid", m0_rvalid, md_rv0);
    chk("m1_rvalid", m1_rvalid, md_rv1);
    if (e_g0) begin
      chk("mem_we_m0", mem_we, m0_we);
      chk("mem_addr_m0", mem_addr, m0_addr);
      chk("mem_wdata_m0", mem_wdata, m0_wdata);
    end
    if (e_g1) begin
      chk("mem_we_m1", mem_we, m1_we);
      chk("mem_addr_m1", mem_addr, m1_addr);
      chk("mem_wdata_m1", mem_wdata, m1_wdata);
    end
    if (md_rv0 || md_rv1) begin
      chk("m0_rdata", m0_rdata, md_rdata);
      chk("m1_rdata", m1_rdata, md_rdata);
    end
  endtask

  // One clock cycle: check, advance model, clock, respond as the memory.
  task automatic tick();
    logic          rd;
    logic [AW-1:0] ra;
    #1;
    check_outputs();
    rd = 1'b0;
    ra = '0;
    if (md_own == 1 && m0_req && !m0_we) begin rd = 1'b1; ra = m0_addr; end
    if (md_own == 2 && m1_req && !m1_we) begin rd = 1'b1; ra = m1_addr; end
    pg0 = (md_own == 1) && m0_req;
    pg1 = (md_own == 2) && m1_req;
    model_step();
    @(posedge clk);
    #1;
    mem_rdata = rd ? memf(ra) : '0;
    @(negedge clk);
  endtask

  int beats1;

  initial begin
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0;
    model_reset();
    #1;
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_m0_gnt", m0_gnt, 1'b0);
    chk("rst_m1_gnt", m1_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read from m0
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    #1;
    chk("rd_c1_owner", 64'(owner), 64'd0);
    chk("rd_c1_gnt", m0_gnt, 1'b0);
    tick();
    #1;
    chk("rd_c2_gnt", m0_gnt, 1'b1);
    chk("rd_c2_en", mem_en, 1'b1);
    chk("rd_c2_addr", mem_addr, 32'h10);
    tick();
    m0_req = 0;
    #1;
    chk("rd_c3_rvalid", m0_rvalid, 1'b1);
    chk("rd_c3_rdata", m0_rdata, memf(32'h10));
    tick();
    tick();

    // Ties
    m0_req = 1; m0_addr = 32'h30; m1_req = 1; m1_we = 0; m1_addr = 32'h34;
    tick();
    #1;
    chk("tie1_owner", 64'(owner), 64'd1);
    tick();
    m0_req = 0; m1_req = 0;
    tick();
    m0_req = 1; m1_req = 1;
    tick();
    #1;
    chk("tie2_owner", 64'(owner), RR ? 64'd2 : 64'd1);
    m0_req = 0; m1_req = 0;
    tick();
    tick();

    // Preemption of m1 by m0 after MAX_BURST beats
    m1_req = 1; m1_we = 0; m1_addr = 32'h100;
    m0_we = 0; m0_addr = 32'h40;
    tick();
    beats1 = 0;
    for (int k = 1; k <= 4; k++) begin
      m1_addr = 32'h100 + 32'(k);
      m0_req = (k >= 2);
      #1;
      if (m1_gnt && m1_req) beats1++;
      tick();
    end
    #1;
    chk("pre_owner", 64'(owner), 64'd1);
    chk("pre_m1_beats", 64'(beats1), 64'd4);
    chk("pre_m1_gnt", m1_gnt, 1'b0);
    chk("pre_m1_rvalid", m1_rvalid, 1'b1);
    chk("pre_m1_rdata", m1_rdata, memf(32'h104));
    chk("pre_m0_rvalid", m0_rvalid, 1'b0);
    tick();
    m0_req = 0;
    repeat (3) tick();
    m1_req = 0;
    repeat (2) tick();

    // Write burst from m0
    m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'hDEADBEEF;
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wr_we", mem_we, 1'b1);
      chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
      chk("wr_no_rvalid", m0_rvalid, 1'b0);
      tick();
    end
    m0_req = 0; m0_we = 0;
    #1;
    chk("wr_end_rvalid", m0_rvalid, 1'b0);
    tick();
    tick();

    // Reset in the middle of an m1 read burst
    m1_req = 1; m1_we = 0; m1_addr = 32'h200;
    tick();
    tick();
    m1_addr = 32'h204;
    #1;
    chk("rstm_pre_gnt", m1_gnt, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rstm_gnt", m1_gnt, 1'b0);
    chk("rstm_en", mem_en, 1'b0);
    chk("rstm_owner", 64'(owner), 64'd0);
    @(posedge clk);
    #1;
    mem_rdata = '0;
    chk("rstm_rvalid", m1_rvalid, 1'b0);
    @(negedge clk);
    m1_req = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m0_req = 1; m0_addr = 32'h50; m1_req = 1; m1_addr = 32'h54;
    tick();
    #1;
    chk("rstm_tie_owner", 64'(owner), 64'd1);
    m0_req = 0; m1_req = 0;
    repeat (2) tick();

    // Random traffic honouring the hold-while-waiting rule
    for (int c = 0; c < 400; c++) begin
      if (!(m0_req && !pg0)) begin
        m0_req   = ($urandom_range(0, 99) < 60);
        m0_we    = $urandom_range(0, 1) == 1;
        m0_addr  = AW'($urandom_range(0, 255));
        m0_wdata = DW'($urandom);
      end
      if (!(m1_req && !pg1)) begin
        m1_req   = ($urandom_range(0, 99) < 70);
        m1_we    = $urandom_range(0, 1) == 1;
        m1_addr  = AW'($urandom_range(256, 511));
        m1_wdata = DW'($urandom);
      end
      tick();
    end
    m0_req = 0; m1_req = 0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
